cabac_renorm_ctrl: RTL
======================

# cabac_renorm_ctrl

Renormalization sequencer for the VVC arithmetic decoder. It accepts a post-decode `(range, offset)` pair and looks up the shift count in the renorm-shift ROM. It pulls the required bits from a byte-wide bitstream port through an internal 16-bit bit buffer and returns the renormalized pair. It also performs slice-start engine initialization: `range=510` and a 9-bit offset load.

## Interface
Parameters:
- `BUF_W`, 16: bit-buffer width. Must be ≥ 16.

Ports:
- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: reset. Synchronous, active-high.
- `init_valid`  in  1: request engine init; only sampled in IDLE.
- `flush`  in  1: discard buffered bits; only honored in IDLE.
- `req_valid`  in  1: renorm request valid.
- `req_ready`  out  1: equals `state==IDLE && !init_valid`.
- `req_range`  in  9: pre-renorm range, legal range 4..510.
- `req_offset`  in  9: pre-renorm offset.
- `resp_valid`  out  1: result valid.
- `resp_ready`  in  1: consumer accepts result.
- `resp_range`  out  9: renormalized range.
- `resp_offset`  out  9: renormalized offset.
- `bs_valid`  in  1: bitstream byte valid.
- `bs_ready`  out  1: equals `cnt <= BUF_W-8`.
- `bs_data`  in  8: bitstream byte, MSB first.

## Operation
- States: IDLE, INIT, SHIFT, RESP.
- Bit buffer: `buf`, MSB = oldest bit, `cnt` valid bits (0..16). A byte handshake appends 8 bits directly behind the valid bits.
- Consume and append in the same cycle: consume first, then append. `cnt_next = cnt - n + 8`.
- IDLE:
  - `flush` → `cnt=0`.
  - `init_valid` → INIT. Init has priority over `req_valid`.
  - `req_valid && req_ready` → latch range and offset, go to SHIFT.
- INIT:
  - Wait until `cnt ≥ 9`.
  - Then `range=510`, `offset=buf[15:7]`, `cnt -= 9`, go to RESP.
- SHIFT:
  - `n = range[8] ? 0 : rom[range[7:3]]`. The ROM is combinational.
  - If `cnt ≥ n`: `range <<= n`, `offset = (offset<<n) | top n bits of buf`, `cnt -= n`, go to RESP.
  - Else stay in SHIFT (starved). Nothing is modified.
  - `n=0` is a pass-through and consumes no bits.
- RESP:
  - `resp_valid=1`.
  - `resp_valid && resp_ready` → IDLE.
- Arithmetic truncates to 9 bits.
  - For legal inputs the result satisfies 256 ≤ range ≤ 510.
  - Inputs below 4 are illegal. The result for them is undefined but must not hang the FSM.
- Buffer filling continues in every state whenever `bs_ready` is high.

## Timing
- Reset values:
  - `state=IDLE`, `cnt=0`, `buf=0`.
  - `resp_valid=0`, `resp_range=0`, `resp_offset=0`.
  - `req_ready=1`, `bs_ready=1`.
- Latency with enough bits buffered: request accepted in cycle 0, SHIFT in cycle 1, `resp_valid` in cycle 2.
- Init latency: 2 cycles once `cnt ≥ 9`.
- Starvation adds one cycle per missing byte. The byte arriving in cycle k allows the shift in cycle k+1.
- `resp_*` holds stable while `resp_valid && !resp_ready`.
- `req_ready` is low in every state other than IDLE.
- `rst` mid-operation (any state): next cycle is IDLE, the buffer is empty, the in-flight request is dropped, and `resp_valid=0`.
- Boundary conditions:
  - `cnt=16` (full): `bs_ready=0`.
  - `cnt=8`: `bs_ready=1`.
  - `flush` outside IDLE is ignored.

## Structure
- Shared package `cabac_pkg` holds:
  - `RANGE_W=9`
  - `INIT_RANGE=9'd510`
  - FSM state encodings
  - `BYTE_W=8`
- Sub-module: instantiate the existing `RenormTableROM`.
  - `addr` = `range[7:3]`.
  - Only `data_out[2:0]` is used.
- Expected size: ~200 lines of RTL.

## Test plan
- **Init:** bytes 0xA5, 0x3C, then `init_valid` → `resp_range=510`, `resp_offset=330`, `cnt=7`.
- **Pass-through:** `req_range=300`, `req_offset=100` → response 300/100 in cycle 2, `cnt` unchanged.
- **Max shift:** after init, `req_range=6`, `req_offset=5` (n=6, consumes bits 011110) → `resp_range=384`, `resp_offset=350`, `cnt=1`.
- **Starvation:** `cnt=1` (bit 0), `req_range=100`, `req_offset=50`, `bs_valid` low for 5 cycles → `resp_valid` stays 0. Then 0xFF arrives → `resp_range=400`, `resp_offset=201`, `cnt=7`.
- **Backpressure:** `resp_ready` low for 3 cycles → `resp_*` stable and `req_ready=0` throughout. Completes the cycle after `resp_ready` rises.
- **Reset mid-SHIFT while starved:** assert `rst` for 1 cycle → IDLE, `cnt=0`, `resp_valid=0`, `bs_ready=1`.

Source files
------------

// File: rtl/cabac_pkg.sv
// cabac_pkg: shared widths, init constant and renorm FSM states for the CABAC decoder engine
package cabac_pkg;
   localparam int RANGE_W = 9;
   localparam int BYTE_W = 8;
   localparam logic [RANGE_W-1:0] INIT_RANGE = 9'd510;
   typedef enum logic [1:0] {IDLE, INIT, SHIFT, RESP} state_t;
endpackage

// File: rtl/cabac_renorm_ctrl_rom.sv
// RenormTableROM: renorm shift count indexed by range[7:3], i.e. 8 - floor(log2(range)) for range < 256
module RenormTableROM (
   input  logic [4:0] addr,
   output logic [7:0] data_out
);
   always_comb data_out = addr == 5'd0 ? 8'd6 :
                          addr == 5'd1 ? 8'd5 :
                          addr <  5'd4 ? 8'd4 :
                          addr <  5'd8 ? 8'd3 :
                          addr < 5'd16 ? 8'd2 : 8'd1;
endmodule

// File: rtl/cabac_renorm_ctrl.sv
// cabac_renorm_ctrl: renormalizes (range, offset) after a bin decode and performs engine init,
// pulling bits MSB-first from a byte-wide bitstream through a small bit buffer
module cabac_renorm_ctrl
   import cabac_pkg::*;
#(
   parameter int BUF_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init_valid,
   input  logic               flush,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [RANGE_W-1:0] req_range,
   input  logic [RANGE_W-1:0] req_offset,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [RANGE_W-1:0] resp_range,
   output logic [RANGE_W-1:0] resp_offset,
   input  logic               bs_valid,
   output logic               bs_ready,
   input  logic [BYTE_W-1:0]  bs_data
);
   localparam int CW = $clog2(BUF_W + 1);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_sh, take;
   logic [BUF_W-1:0] bit_buf, bits_n, bits_sh;
   logic [RANGE_W-1:0] range_q, offset_q, range_n, offset_n;
   logic [RANGE_W+BUF_W-1:0] cat;
   logic [7:0] rom_data;
   logic [2:0] n;
   logic unused_rom;
   logic clear;
   RenormTableROM u_rom (
      .addr     (range_q[7:3]),
      .data_out (rom_data)
   );
   assign n = range_q[8] ? 3'd0 : rom_data[2:0];
   assign unused_rom = ^rom_data[7:3];
   assign req_ready = state == IDLE && !init_valid;
   assign bs_ready = cnt <= CW'(BUF_W - BYTE_W);
   assign resp_valid = state == RESP;
   assign resp_range = range_q;
   assign resp_offset = offset_q;
   assign clear = state == IDLE && flush;
   always_comb begin
      state_n = state;
      range_n = range_q;
      offset_n = offset_q;
      take = '0;
      cat = {offset_q, bit_buf} << n;
      case (state)
         IDLE: begin
            if (init_valid) state_n = INIT;
            else if (req_valid) begin
               state_n = SHIFT;
               range_n = req_range;
               offset_n = req_offset;
            end
         end
         INIT: begin
            if (cnt >= CW'(RANGE_W)) begin
               state_n = RESP;
               range_n = INIT_RANGE;
               offset_n = bit_buf[BUF_W-1 -: RANGE_W];
               take = CW'(RANGE_W);
            end
         end
         SHIFT: begin
            // starved: hold everything until enough bits are buffered
            if (cnt >= CW'(n)) begin
               state_n = RESP;
               range_n = range_q << n;
               offset_n = cat[RANGE_W+BUF_W-1 -: RANGE_W];
               take = CW'(n);
            end
         end
         RESP: state_n = resp_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
      cnt_sh = clear ? '0 : cnt - take;
      bits_sh = clear ? '0 : bit_buf << take;
      bits_n = bs_valid && bs_ready ? bits_sh | ({bs_data, {(BUF_W-BYTE_W){1'b0}}} >> cnt_sh) : bits_sh;
      cnt_n = bs_valid && bs_ready ? cnt_sh + CW'(BYTE_W) : cnt_sh;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_buf <= '0;
         range_q <= '0;
         offset_q <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_buf <= bits_n;
         range_q <= range_n;
         offset_q <= offset_n;
      end
   end
endmodule
